// File: rtl/ofm_accumulate_writeback_pkg.sv
// ofm_accumulate_writeback_pkg: widths, FSM state encoding and saturation helpers
package ofm_accumulate_writeback_pkg;
    localparam int TM            = 16;
    localparam int FEATURE_WIDTH = 16;
    localparam int ACC_WIDTH     = 24;
    localparam int ADDR_WIDTH    = 12;
    localparam int CH_W          = $clog2(TM);
    typedef enum logic [1:0] {
        OFM_IDLE  = 2'd0,
        OFM_ACCUM = 2'd1,
        OFM_WRITE = 2'd2
    } ofm_state_e;
    // One guard bit above the accumulator: top two bits differ only on overflow.
    function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] x);
        return (x[ACC_WIDTH] == x[ACC_WIDTH-1]) ? x[ACC_WIDTH-1:0] :
               x[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction
    // In range when every bit from the feature sign bit upward agrees.
    function automatic logic [FEATURE_WIDTH-1:0] sat_feat(input logic [ACC_WIDTH-1:0] x);
        return (&x[ACC_WIDTH-1:FEATURE_WIDTH-1] || ~|x[ACC_WIDTH-1:FEATURE_WIDTH-1]) ? x[FEATURE_WIDTH-1:0] :
               x[ACC_WIDTH-1] ? {1'b1, {(FEATURE_WIDTH-1){1'b0}}} : {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
    endfunction
endpackage

// File: rtl/ofm_accumulate_writeback_if.sv
// ofm_accumulate_writeback_if: feature stream in, OFM write port out
//   feature_valid/feature_in : serial scaled features, one channel per cycle
//   ofm_wr_en/ofm_wr_ready   : write request / accept handshake
//   ofm_wr_addr/ofm_wr_data  : pixel address and packed Tm-lane word (lane 0 at LSBs)
interface ofm_accumulate_writeback_if;
    import ofm_accumulate_writeback_pkg::*;
    logic                          feature_valid;
    logic [FEATURE_WIDTH-1:0]      feature_in;
    logic                          ofm_wr_en;
    logic                          ofm_wr_ready;
    logic [ADDR_WIDTH-1:0]         ofm_wr_addr;
    logic [TM*FEATURE_WIDTH-1:0]   ofm_wr_data;
    modport master (output feature_valid, feature_in, ofm_wr_ready,
                    input  ofm_wr_en, ofm_wr_addr, ofm_wr_data);
    modport slave  (input  feature_valid, feature_in, ofm_wr_ready,
                    output ofm_wr_en, ofm_wr_addr, ofm_wr_data);
endinterface

// File: rtl/ofm_accumulate_writeback_sat_relu_lane.sv
// ofm_accumulate_writeback_sat_relu_lane: combinational accumulator-to-feature saturate plus optional ReLU
//   acc_i     : lane accumulator (signed, ACC_WIDTH)
//   relu_en_i : clamp negative results to zero
//   feat_o    : saturated lane output (signed, FEATURE_WIDTH)
module ofm_accumulate_writeback_sat_relu_lane
    import ofm_accumulate_writeback_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]     acc_i,
    input  logic                     relu_en_i,
    output logic [FEATURE_WIDTH-1:0] feat_o
);
    logic [FEATURE_WIDTH-1:0] sat;
    assign sat    = sat_feat(acc_i);
    assign feat_o = (relu_en_i && sat[FEATURE_WIDTH-1]) ? '0 : sat;
endmodule

// File: rtl/ofm_accumulate_writeback.sv
// ofm_accumulate_writeback: accumulates Tm-lane partial sums over input tiles and writes one packed word
//   clk, rst_n      : clock, asynchronous active-low reset
//   acc_start_i     : begin one output pixel (taken only in IDLE)
//   num_tiles_i     : input tiles to accumulate, 0 treated as 1
//   pixel_addr_i    : destination address; relu_en_i : ReLU on write
//   bus             : feature stream and OFM write port
//   busy_o, done_o  : ACCUM/WRITE indicator, one-cycle completion pulse
//   protocol_err_o  : sticky, feature_valid seen outside ACCUM
module ofm_accumulate_writeback
    import ofm_accumulate_writeback_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       acc_start_i,
    input  logic [7:0]                 num_tiles_i,
    input  logic [ADDR_WIDTH-1:0]      pixel_addr_i,
    input  logic                       relu_en_i,
    ofm_accumulate_writeback_if.slave  bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       protocol_err_o
);
    ofm_state_e                  state_q, state_d;
    logic [ACC_WIDTH-1:0]        bank_q [TM];
    logic [CH_W-1:0]             ch_q;
    logic [7:0]                  tile_q, ntiles_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic                        relu_q, done_q, err_q;
    logic                        accept, last;
    logic [TM*FEATURE_WIDTH-1:0] lane_data;

    assign accept = state_q == OFM_ACCUM && bus.feature_valid;
    assign last   = ch_q == CH_W'(TM-1) && tile_q == ntiles_q - 8'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFM_IDLE:  state_d = acc_start_i ? OFM_ACCUM : OFM_IDLE;
            OFM_ACCUM: state_d = (accept && last) ? OFM_WRITE : OFM_ACCUM;
            OFM_WRITE: state_d = bus.ofm_wr_ready ? OFM_IDLE : OFM_WRITE;
            default:   state_d = OFM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= OFM_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TM; i++) bank_q[i] <= '0;
            ch_q     <= '0;
            tile_q   <= '0;
            ntiles_q <= '0;
            addr_q   <= '0;
            relu_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= state_q == OFM_WRITE && bus.ofm_wr_ready;
            err_q  <= err_q | (bus.feature_valid && state_q != OFM_ACCUM);
            if (state_q == OFM_IDLE && acc_start_i) begin
                for (int i = 0; i < TM; i++) bank_q[i] <= '0;
                ch_q     <= '0;
                tile_q   <= '0;
                ntiles_q <= (num_tiles_i == 8'd0) ? 8'd1 : num_tiles_i;
                addr_q   <= pixel_addr_i;
                relu_q   <= relu_en_i;
            end else if (accept) begin
                // Sign-extend both operands by one guard bit so overflow is visible to sat_acc.
                bank_q[ch_q] <= sat_acc({bank_q[ch_q][ACC_WIDTH-1], bank_q[ch_q]} +
                                        {{(ACC_WIDTH+1-FEATURE_WIDTH){bus.feature_in[FEATURE_WIDTH-1]}}, bus.feature_in});
                ch_q <= ch_q + CH_W'(1);
                if (ch_q == CH_W'(TM-1)) tile_q <= tile_q + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < TM; g++) begin : g_lane
        ofm_accumulate_writeback_sat_relu_lane u_lane (
            .acc_i     (bank_q[g]),
            .relu_en_i (relu_q),
            .feat_o    (lane_data[g*FEATURE_WIDTH +: FEATURE_WIDTH])
        );
    end

    // Write port is derived from state_q, so an asynchronous reset drops it at once.
    assign bus.ofm_wr_en   = state_q == OFM_WRITE;
    assign bus.ofm_wr_addr = bus.ofm_wr_en ? addr_q : '0;
    assign bus.ofm_wr_data = bus.ofm_wr_en ? lane_data : '0;
    assign busy_o          = state_q != OFM_IDLE;
    assign done_o          = done_q;
    assign protocol_err_o  = err_q;
endmodule

// File: tb/tb_ofm_accumulate_writeback.sv
// tb_ofm_accumulate_writeback: directed stimulus against a behavioural accumulate/saturate/write model
module tb_ofm_accumulate_writeback;
    import ofm_accumulate_writeback_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, acc_start = 1'b0, relu_en = 1'b0;
    logic [7:0]  num_tiles = '0;
    logic [11:0] pixel_addr = '0;
    logic        busy, done, protocol_err;

    ofm_accumulate_writeback_if bus();

    ofm_accumulate_writeback dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .acc_start_i    (acc_start),
        .num_tiles_i    (num_tiles),
        .pixel_addr_i   (pixel_addr),
        .relu_en_i      (relu_en),
        .bus            (bus),
        .busy_o         (busy),
        .done_o         (done),
        .protocol_err_o (protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int           m[16];
    int           m_nt;
    bit           m_relu;
    logic [11:0]  m_addr;
    logic [255:0] q_data[$];
    logic [11:0]  q_addr[$];
    bit           err_exp = 1'b0, exp_done = 1'b0;
    logic [255:0] last_data = '0;
    logic [11:0]  last_addr = '0;
    int           wr_count = 0;

    function automatic int sat(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        return int'(v > hi ? hi : (v < lo ? lo : v));
    endfunction

    function automatic logic [255:0] model_word();
        logic [255:0] w = '0;
        for (int i = 0; i < 16; i++) begin
            int v = sat(m[i], 16);
            if (m_relu && v < 0) v = 0;
            w[i*16 +: 16] = v[15:0];
        end
        return w;
    endfunction

    function automatic int feat(input int kind, input int t, input int c);
        case (kind)
            0: return c;
            1: return 5;
            2: return (c == 3) ? ((t == 0) ? -100 : 40) : c + 1;
            3: return 32767;
            4: return -32768;
            5: return 7;
            default: return 3 * c - 10 * t;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_wr_en", bus.ofm_wr_en, 0);
            exp_done = 1'b0;
        end else begin
            chk("done", done, exp_done);
            exp_done = 1'b0;
            chk("protocol_err", protocol_err, err_exp);
            chk("wr_en", bus.ofm_wr_en, q_data.size() != 0);
            if (bus.ofm_wr_en && q_data.size() != 0) begin
                chk("wr_addr", bus.ofm_wr_addr, q_addr[0]);
                chk("wr_data", bus.ofm_wr_data, q_data[0]);
                if (bus.ofm_wr_ready) begin
                    last_data = bus.ofm_wr_data;
                    last_addr = bus.ofm_wr_addr;
                    wr_count++;
                    void'(q_data.pop_front());
                    void'(q_addr.pop_front());
                    exp_done = 1'b1;
                end
            end
        end
    end

    task automatic start(input int nt, input logic [11:0] addr, input bit relu);
        acc_start = 1'b1;
        num_tiles = 8'(nt);
        pixel_addr = addr;
        relu_en = relu;
        foreach (m[i]) m[i] = 0;
        m_relu = relu;
        m_addr = addr;
        m_nt = (nt == 0) ? 1 : nt;
        @(posedge clk); #1;
        acc_start = 1'b0;
        chk("busy_start", busy, 1);
    endtask

    task automatic feed_all(input int kind, input bit gaps, input bit poke);
        for (int t = 0; t < m_nt; t++)
            for (int c = 0; c < 16; c++) begin
                int f = feat(kind, t, c);
                if (gaps && c == 5) begin
                    bus.feature_valid = 1'b0;
                    @(posedge clk); #1;
                end
                bus.feature_valid = 1'b1;
                bus.feature_in = 16'(f);
                if (poke && t == 0 && c == 8) begin
                    acc_start = 1'b1;
                    pixel_addr = ~m_addr;
                end
                m[c] = sat(longint'(m[c]) + f, 24);
                @(posedge clk); #1;
                acc_start = 1'b0;
            end
        bus.feature_valid = 1'b0;
        q_data.push_back(model_word());
        q_addr.push_back(m_addr);
    endtask

    task automatic finish_write(input int hold);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 bus.ofm_wr_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("done_pulse", done, 1);
        chk("wr_en_after", bus.ofm_wr_en, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        bus.feature_valid = 1'b0;
        bus.feature_in = '0;
        bus.ofm_wr_ready = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", protocol_err, 0);
        chk("reset_data", bus.ofm_wr_data, 0);
        chk("reset_addr", bus.ofm_wr_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        start(1, 12'h0A5, 1'b0);
        feed_all(0, 1'b0, 1'b0);
        finish_write(0);
        chk("t1_addr", last_addr, 12'h0A5);
        for (int i = 0; i < 16; i++) chk("t1_lane", last_data[i*16 +: 16], 16'(i));

        start(0, 12'h100, 1'b0);
        feed_all(5, 1'b0, 1'b0);
        finish_write(0);
        chk("t1b_lane0", last_data[15:0], 16'd7);
        chk("t1b_count", wr_count, 2);

        start(3, 12'h200, 1'b0);
        feed_all(1, 1'b1, 1'b0);
        finish_write(0);
        chk("t2_lane0", last_data[15:0], 16'd15);
        chk("t2_lane15", last_data[255:240], 16'd15);
        chk("t2_count", wr_count, 3);

        start(2, 12'h300, 1'b1);
        feed_all(2, 1'b0, 1'b0);
        finish_write(0);
        chk("t3_relu_lane3", last_data[63:48], 16'd0);
        chk("t3_relu_lane4", last_data[79:64], 16'd10);
        start(2, 12'h301, 1'b0);
        feed_all(2, 1'b0, 1'b0);
        finish_write(0);
        chk("t3_lane3", last_data[63:48], 16'hFFC4);

        start(4, 12'h400, 1'b0);
        feed_all(3, 1'b0, 1'b0);
        finish_write(0);
        chk("t4_pos_sat", last_data[15:0], 16'h7FFF);
        start(4, 12'h401, 1'b0);
        feed_all(4, 1'b0, 1'b0);
        finish_write(0);
        chk("t4_neg_sat", last_data[255:240], 16'h8000);
        start(255, 12'h402, 1'b0);
        feed_all(4, 1'b0, 1'b0);
        finish_write(0);
        chk("t4_255_tiles", last_data[127:112], 16'h8000);

        bus.ofm_wr_ready = 1'b0;
        start(2, 12'h3C3, 1'b0);
        feed_all(6, 1'b0, 1'b1);
        finish_write(7);
        chk("t5_addr", last_addr, 12'h3C3);

        start(1, 12'h777, 1'b0);
        for (int c = 0; c < 9; c++) begin
            bus.feature_valid = 1'b1;
            bus.feature_in = 16'd1000;
            @(posedge clk); #1;
        end
        bus.feature_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        start(1, 12'h778, 1'b0);
        feed_all(0, 1'b0, 1'b0);
        finish_write(0);
        chk("t6_fresh_lane5", last_data[95:80], 16'd5);

        bus.ofm_wr_ready = 1'b0;
        start(1, 12'h779, 1'b0);
        feed_all(0, 1'b0, 1'b0);
        q_data.delete();
        q_addr.delete();
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_wr_en", bus.ofm_wr_en, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.ofm_wr_ready = 1'b1;

        bus.feature_valid = 1'b1;
        bus.feature_in = 16'd123;
        @(posedge clk); #1;
        bus.feature_valid = 1'b0;
        err_exp = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("t6_err_sticky", protocol_err, 1);
        start(1, 12'h77A, 1'b0);
        feed_all(5, 1'b0, 1'b0);
        finish_write(0);
        chk("t6_after_err_lane9", last_data[159:144], 16'd7);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
